// File: rtl/reg_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_write_arbiter                                          |
// | Description : Four requesters compete for write access to one shared     |
// |               WIDTH-bit register. The default build uses round-robin     |
// |               arbitration. Defining ARB_FIXED_PRIO_EN switches to fixed  |
// |               priority, where requester 0 is highest.                    |
// |               Each write passes through IDLE -> GRANT -> WRITE. A        |
// |               requester that drops REQ during GRANT aborts its write.    |
// | Ports       : clk   - clock, rising edge                                 |
// |               rst   - asynchronous active-high reset                     |
// |               req   - [3:0] write request, bit i = requester i           |
// |               d     - [4*WIDTH-1:0] data, requester i at [i*WIDTH+:WIDTH]|
// |               gnt   - [3:0] registered one-hot grant                     |
// |               ack   - [3:0] registered one-hot write-complete pulse      |
// |               q     - [WIDTH-1:0] shared register contents               |
// |               busy  - high whenever the FSM is not in IDLE               |
// | Macro       : ARB_FIXED_PRIO_EN (fixed priority instead of round-robin)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] d,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_winner;
  logic [1:0]       w_winner_nxt;
  logic [1:0]       w_pick;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt_nxt;
  logic [3:0]       r_ack;
  logic [3:0]       w_ack_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_slice [4];

  // Split the packed data bus into per-requester slices.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign w_slice[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index active requester wins.
  always_comb begin
    w_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) w_pick = 2'(i);
    end
  end
`else
  logic [1:0] r_last;
  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic       w_commit;

  // Rotate the requests so that bit 0 is requester last+1. The first set
  // bit then gives the offset of the winner from last+1. The 2-bit add
  // wraps modulo 4.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[{1'b0, r_last} + 3'd1 +: 4];

  always_comb begin
    w_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_off = 2'(i);
    end
  end

  assign w_pick   = r_last + 2'd1 + w_off;
  assign w_commit = (r_state == S_GRANT) && req[r_winner];

  // LAST resets to 3, so the first search after reset starts at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 2'd3;
    end else if (w_commit) begin
      r_last <= r_winner;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = req[r_winner] ? S_WRITE : S_IDLE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. This block computes the values that the registered
  // outputs take at the next edge. Outside IDLE and GRANT the grant and ack
  // values default to zero. This makes each ACK a single-cycle pulse and
  // keeps GNT and ACK mutually exclusive.
  always_comb begin
    w_gnt_nxt    = 4'b0000;
    w_ack_nxt    = 4'b0000;
    w_q_nxt      = r_q;
    w_winner_nxt = r_winner;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_winner_nxt = w_pick;
          w_gnt_nxt    = 4'b0001 << w_pick;
        end
      end
      S_GRANT: begin
        // If the winner still requests, commit its data. If it has
        // dropped REQ, abort silently and leave Q untouched.
        if (req[r_winner]) begin
          w_q_nxt   = w_slice[r_winner];
          w_ack_nxt = 4'b0001 << r_winner;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and winner latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= 4'b0000;
      r_ack    <= 4'b0000;
      r_q      <= '0;
      r_winner <= 2'd0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_ack    <= w_ack_nxt;
      r_q      <= w_q_nxt;
      r_winner <= w_winner_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign q    = r_q;
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
